// File: rtl/vga_sprite_engine_if.sv
// Pixel-timing and ROM bundle for the sprite engine.
// The master side supplies coordinates and ROM data; the slave drives address and colour.
interface vga_sprite_engine_if #(
  parameter int ADDR_W = 15
);
  logic [10:0]       hc;
  logic [10:0]       vc;
  logic              blank;
  logic [10:0]       x0;
  logic [10:0]       y0;
  logic              pos_load;
  logic [7:0]        mem_value;
  logic [ADDR_W-1:0] rom_addr;
  logic [2:0]        R;
  logic [2:0]        G;
  logic [1:0]        B;
  logic              hit;

  modport master (
    output hc, vc, blank, x0, y0, pos_load, mem_value,
    input  rom_addr, R, G, B, hit
  );

  modport slave (
    input  hc, vc, blank, x0, y0, pos_load, mem_value,
    output rom_addr, R, G, B, hit
  );
endinterface

// File: rtl/vga_sprite_engine.sv
// Scaled, colour-keyed sprite overlay with double-buffered position.
// Fixed latency of ROM_LAT+2 clocks from hc/vc to RGB/hit.
module vga_sprite_engine #(
  parameter int          IMG_W    = 344,
  parameter int          IMG_H    = 48,
  parameter int          ADDR_W   = 15,
  parameter int          SCALE_SH = 0,
  parameter int          ROM_LAT  = 1,
  parameter int          KEY_EN   = 1,
  parameter logic [7:0]  KEY      = 8'hE3,
  parameter logic [7:0]  BG       = 8'h00
) (
  input logic clk,
  input logic rst,
  vga_sprite_engine_if.slave sp
);

  localparam logic [11:0] BOX_W = 12'(IMG_W << SCALE_SH);
  localparam logic [11:0] BOX_H = 12'(IMG_H << SCALE_SH);

  logic [10:0] shx_q, shx_d;
  logic [10:0] shy_q, shy_d;
  logic [10:0] ax_q, ax_d;
  logic [10:0] ay_q, ay_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ROM_LAT:0]  vld_q, box_q, blk_q;
  logic [7:0]        rgb_q, rgb_d;
  logic              hit_q, hit_d;

  logic [11:0] hc12, vc12, ax12, ay12;
  logic [11:0] dx, dy, sx, sy;
  logic        frame_start;
  logic        in_box;

  // A load in the frame-start cycle lands in shadow only.
  always_comb begin
    frame_start = (sp.hc == 11'd0) && (sp.vc == 11'd0);
    shx_d = sp.pos_load ? sp.x0 : shx_q;
    shy_d = sp.pos_load ? sp.y0 : shy_q;
    ax_d  = frame_start ? shx_q : ax_q;
    ay_d  = frame_start ? shy_q : ay_q;
  end

  always_comb begin
    hc12   = {1'b0, sp.hc};
    vc12   = {1'b0, sp.vc};
    ax12   = {1'b0, ax_q};
    ay12   = {1'b0, ay_q};
    in_box = (hc12 >= ax12) && (hc12 < ax12 + BOX_W) &&
             (vc12 >= ay12) && (vc12 < ay12 + BOX_H);
    dx     = hc12 - ax12;
    dy     = vc12 - ay12;
    sx     = dx >> SCALE_SH;
    sy     = dy >> SCALE_SH;
    addr_d = '0;
    if (in_box)
      addr_d = ADDR_W'(sy) * ADDR_W'(IMG_W) + ADDR_W'(sx);
  end

  localparam int L = ROM_LAT;

  always_comb begin
    rgb_d = BG;
    hit_d = 1'b0;
    if (!vld_q[L] || blk_q[L]) begin
      rgb_d = 8'h00;
    end else if (!box_q[L]) begin
      rgb_d = BG;
    end else if ((KEY_EN != 0) && (sp.mem_value == KEY)) begin
      rgb_d = BG;
    end else begin
      rgb_d = sp.mem_value;
      hit_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shx_q  <= '0;
      shy_q  <= '0;
      ax_q   <= '0;
      ay_q   <= '0;
      addr_q <= '0;
      vld_q  <= '0;
      box_q  <= '0;
      blk_q  <= '0;
      rgb_q  <= '0;
      hit_q  <= 1'b0;
    end else begin
      shx_q  <= shx_d;
      shy_q  <= shy_d;
      ax_q   <= ax_d;
      ay_q   <= ay_d;
      addr_q <= addr_d;
      vld_q  <= {vld_q[L-1:0], 1'b1};
      box_q  <= {box_q[L-1:0], in_box};
      blk_q  <= {blk_q[L-1:0], sp.blank};
      rgb_q  <= rgb_d;
      hit_q  <= hit_d;
    end
  end

  assign sp.rom_addr = addr_q;
  assign sp.R        = rgb_q[7:5];
  assign sp.G        = rgb_q[4:2];
  assign sp.B        = rgb_q[1:0];
  assign sp.hit      = hit_q;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench: two engine configurations fed from one pixel stream.
// Vector tables cover addressing; hand sequences cover buffering, blank and reset.
module tb_vga_sprite_engine;

  typedef struct {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        blank;
    int          addr;
    int          rgb;
    int          hit;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hc = 11'd2047;
  logic [10:0] vc = 11'd2047;
  logic [10:0] x0 = 11'd0;
  logic [10:0] y0 = 11'd0;
  logic        blank = 1'b0;
  logic        pos_load = 1'b0;
  logic [7:0]  mem0;
  logic [7:0]  p1 [3];

  int n_chk = 0;
  int n_fail = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  vga_sprite_engine_if #(.ADDR_W(15)) bus0 ();
  vga_sprite_engine_if #(.ADDR_W(15)) bus1 ();

  assign bus0.hc = hc;
  assign bus0.vc = vc;
  assign bus0.blank = blank;
  assign bus0.x0 = x0;
  assign bus0.y0 = y0;
  assign bus0.pos_load = pos_load;
  assign bus0.mem_value = mem0;
  assign bus1.hc = hc;
  assign bus1.vc = vc;
  assign bus1.blank = blank;
  assign bus1.x0 = x0;
  assign bus1.y0 = y0;
  assign bus1.pos_load = pos_load;
  assign bus1.mem_value = p1[2];

  vga_sprite_engine u0 (
    .clk (clk),
    .rst (rst),
    .sp  (bus0)
  );

  vga_sprite_engine #(
    .SCALE_SH (1),
    .ROM_LAT  (3),
    .KEY_EN   (0),
    .BG       (8'h25)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .sp  (bus1)
  );

  function automatic logic [7:0] rom_f(input logic [14:0] a);
    if (a == 15'd5) return 8'hE3;
    return a[7:0] ^ 8'h81;
  endfunction

  always @(posedge clk) begin
    mem0  <= rom_f(bus0.rom_addr);
    p1[0] <= rom_f(bus1.rom_addr);
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end

  function automatic int g_addr(input int sel);
    return (sel == 1) ? int'(bus1.rom_addr) : int'(bus0.rom_addr);
  endfunction

  function automatic int g_rgb(input int sel);
    if (sel == 1) return int'({bus1.R, bus1.G, bus1.B});
    return int'({bus0.R, bus0.G, bus0.B});
  endfunction

  function automatic int g_hit(input int sel);
    return (sel == 1) ? int'(bus1.hit) : int'(bus0.hit);
  endfunction

  function automatic vec_t mk(int h, int v, int b, int a, int c, int t);
    vec_t r;
    r.hc = 11'(h);
    r.vc = 11'(v);
    r.blank = b[0];
    r.addr = a;
    r.rgb = c;
    r.hit = t;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drv(input int h, input int v, input int b);
    hc = 11'(h);
    vc = 11'(v);
    blank = b[0];
  endtask

  task automatic run_table(input int sel, input int lat);
    int n;
    int l;
    int k;
    n = tv.size();
    l = lat + 2;
    for (int i = 0; i < n + l - 1; i++) begin
      if (i < n) drv(int'(tv[i].hc), int'(tv[i].vc), int'(tv[i].blank));
      else drv(2047, 2047, 0);
      step();
      if (i < n)
        chk($sformatf("t%0d_%0d_addr", sel, i), g_addr(sel), tv[i].addr);
      k = i - (l - 1);
      if (k >= 0) begin
        chk($sformatf("t%0d_%0d_rgb", sel, k), g_rgb(sel), tv[k].rgb);
        chk($sformatf("t%0d_%0d_hit", sel, k), g_hit(sel), tv[k].hit);
      end
    end
  endtask

  task automatic load(input int x, input int y);
    pos_load = 1'b1;
    x0 = 11'(x);
    y0 = 11'(y);
    drv(2047, 2047, 0);
    step();
    pos_load = 1'b0;
    drv(0, 0, 0);
    step();
  endtask

  initial begin
    step();
    step();
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst%0d_addr", s), g_addr(s), 0);
      chk($sformatf("rst%0d_rgb", s), g_rgb(s), 0);
      chk($sformatf("rst%0d_hit", s), g_hit(s), 0);
    end
    rst = 1'b0;

    // Unscaled sprite at (100,50), single-cycle ROM
    load(100, 50);
    tv.delete();
    tv.push_back(mk(100, 50, 0, 0, 'h81, 1));
    tv.push_back(mk(101, 50, 0, 1, 'h80, 1));
    tv.push_back(mk(443, 51, 0, 687, 'h2E, 1));
    tv.push_back(mk(444, 51, 0, 0, 'h00, 0));
    tv.push_back(mk(99, 50, 0, 0, 'h00, 0));
    tv.push_back(mk(105, 50, 0, 5, 'h00, 0));
    tv.push_back(mk(100, 97, 0, 16168, 'hA9, 1));
    tv.push_back(mk(100, 98, 0, 0, 'h00, 0));
    tv.push_back(mk(102, 50, 1, 2, 'h00, 0));
    tv.push_back(mk(110, 60, 0, 3450, 'hFB, 1));
    tv.push_back(mk(2000, 50, 0, 0, 'h00, 0));
    run_table(0, 1);

    // 2x sprite at (0,0), keying off, three-cycle ROM, BG 0x25
    load(0, 0);
    tv.delete();
    tv.push_back(mk(0, 0, 0, 0, 'h81, 1));
    tv.push_back(mk(1, 0, 0, 0, 'h81, 1));
    tv.push_back(mk(2, 0, 0, 1, 'h80, 1));
    tv.push_back(mk(3, 0, 0, 1, 'h80, 1));
    tv.push_back(mk(0, 2, 0, 344, 'hD9, 1));
    tv.push_back(mk(10, 0, 0, 5, 'hE3, 1));
    tv.push_back(mk(688, 0, 0, 0, 'h25, 0));
    tv.push_back(mk(687, 95, 0, 16511, 'hFE, 1));
    tv.push_back(mk(0, 96, 0, 0, 'h25, 0));
    tv.push_back(mk(4, 0, 1, 2, 'h00, 0));
    tv.push_back(mk(4, 0, 0, 2, 'h83, 1));
    run_table(1, 3);

    // Blank rising: output goes dark on exactly the fifth edge
    drv(4, 0, 0);
    for (int s = 0; s < 6; s++) step();
    chk("blk_pre_rgb", g_rgb(1), 'h83);
    blank = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      step();
      chk($sformatf("blk_hold%0d_hit", s), g_hit(1), 1);
    end
    step();
    chk("blk_dark_rgb", g_rgb(1), 0);
    chk("blk_dark_hit", g_hit(1), 0);

    // Mid-line reset pulse and pipeline refill
    blank = 1'b0;
    for (int s = 0; s < 6; s++) step();
    chk("rp_pre_hit", g_hit(1), 1);
    rst = 1'b1;
    step();
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rp%0d_addr", s), g_addr(s), 0);
      chk($sformatf("rp%0d_rgb", s), g_rgb(s), 0);
      chk($sformatf("rp%0d_hit", s), g_hit(s), 0);
    end
    rst = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      step();
      chk($sformatf("rf%0d_rgb", s), g_rgb(1), 0);
      chk($sformatf("rf%0d_hit", s), g_hit(1), 0);
    end
    step();
    chk("rf5_rgb", g_rgb(1), 'h83);
    chk("rf5_hit", g_hit(1), 1);

    // Double-buffered position on the default engine
    load(100, 50);
    pos_load = 1'b1;
    x0 = 11'd200;
    drv(300, 10, 0);
    step();
    pos_load = 1'b0;
    drv(200, 50, 0);
    step();
    chk("db_old_addr", g_addr(0), 100);
    drv(100, 50, 0);
    step();
    chk("db_old_org", g_addr(0), 0);
    drv(2047, 2047, 0);
    step();
    step();
    chk("db_old_hit", g_hit(0), 1);
    chk("db_old_rgb", g_rgb(0), 'h81);
    pos_load = 1'b1;
    x0 = 11'd300;
    drv(0, 0, 0);
    step();
    pos_load = 1'b0;
    drv(200, 50, 0);
    step();
    chk("db_new_addr", g_addr(0), 0);
    drv(2047, 2047, 0);
    step();
    step();
    chk("db_new_hit", g_hit(0), 1);
    drv(100, 50, 0);
    step();
    drv(2047, 2047, 0);
    step();
    step();
    chk("db_gone_hit", g_hit(0), 0);
    drv(300, 50, 0);
    step();
    chk("db_pend_addr", g_addr(0), 100);
    drv(0, 0, 0);
    step();
    drv(301, 50, 0);
    step();
    chk("db_next_addr", g_addr(0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sprite_engine.md
VGA_SPRITE_ENGINE -- requirements
Module: vga_sprite_engine

Interface
REQ-001 Parameter IMG_W, default 344: sprite width in source pixels.
REQ-002 Parameter IMG_H, default 48: sprite height in source pixels.
REQ-003 Parameter ADDR_W, default 15: ROM address width; IMG_W*IMG_H SHALL fit in 2^ADDR_W.
REQ-004 Parameter SCALE_SH, default 0, range 0..2: on-screen magnification is 2^SCALE_SH in x and y.
REQ-005 Parameter ROM_LAT, default 1, range 1..3: cycles from rom_addr change to matching mem_value.
REQ-006 Parameter KEY_EN, default 1: enables colour-key transparency.
REQ-007 Parameter KEY, default 8'hE3: transparent colour code.
REQ-008 Parameter BG, default 8'h00: colour output where no sprite pixel is drawn.
REQ-009 clk  in  1  pixel clock; all logic rises on posedge clk.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 hc, vc  in  11 each  current pixel coordinates.
REQ-012 blank  in  1  high outside the visible area.
REQ-013 x0, y0  in  11 each  requested top-left position.
REQ-014 pos_load  in  1  one-cycle strobe capturing x0/y0 into the shadow register.
REQ-015 mem_value  in  8  ROM data, {R[2:0],G[2:0],B[1:0]}.
REQ-016 rom_addr  out  ADDR_W  registered ROM address.
REQ-017 R, G  out  3 each; B  out  2  registered colour.
REQ-018 hit  out  1  registered; high when an opaque sprite pixel is driven, aligned with RGB.

Function
REQ-019 Position SHALL be double-buffered: pos_load copies x0/y0 to shadow; shadow copies to active position only on the cycle hc==0 && vc==0; a pos_load in that same cycle SHALL reach shadow only and apply next frame.
REQ-020 Box test SHALL use 12-bit arithmetic: in_box = hc>=ax && hc<ax+(IMG_W<<SCALE_SH) && vc>=ay && vc<ay+(IMG_H<<SCALE_SH), with no wrap when the box extends past 2047.
REQ-021 Inside box, offsets are sx=(hc-ax)>>SCALE_SH and sy=(vc-ay)>>SCALE_SH; rom_addr SHALL equal sy*IMG_W+sx, registered one cycle after hc/vc are sampled.
REQ-022 Outside box, rom_addr SHALL be 0; pixel (0,0) of the sprite SHALL be drawn normally, not forced to BG.
REQ-023 in_box and blank SHALL be delayed through a shift pipeline so they align with mem_value ROM_LAT cycles after rom_addr.
REQ-024 Output stage, registered: if aligned blank -> RGB=0, hit=0; else if !aligned in_box -> RGB=BG, hit=0; else if KEY_EN && mem_value==KEY -> RGB=BG, hit=0; else RGB=mem_value, hit=1.
REQ-025 Total latency hc/vc -> RGB/hit SHALL be exactly ROM_LAT+2 cycles, constant for every pixel.
REQ-026 Changing hc/vc every cycle SHALL sustain one pixel per clock, with no stalls.

Reset
REQ-027 While rst is high: rom_addr=0, RGB=0, hit=0, all pipeline valid/in_box bits=0, shadow and active position=0.
REQ-028 Reset mid-frame SHALL take effect at the next edge; the ROM_LAT+2 cycles after release SHALL output RGB=0, hit=0 until the pipeline refills.

Verification
REQ-029 Defaults, pos_load x0=100,y0=50 at frame start, hc=100,vc=50 then hc=101 -> rom_addr 0 then 1; RGB=mem_value 3 cycles after each sample.
REQ-030 hc=443,vc=51 (last column, row 1) -> rom_addr=687; hc=444 -> rom_addr=0, RGB=BG, hit=0.
REQ-031 SCALE_SH=1, box at (0,0), hc=0..3,vc=0 -> rom_addr sequence 0,0,1,1; vc=2 -> row 1 base 344.
REQ-032 mem_value=8'hE3 inside box, KEY_EN=1 -> RGB=BG, hit=0; KEY_EN=0 -> RGB=E3, hit=1.
REQ-033 pos_load x0=200 mid-frame -> drawing stays at old x0 until hc==0&&vc==0, then moves to 200.
REQ-034 ROM_LAT=3 with blank toggling -> RGB/hit zero exactly 5 cycles after blank rises; rst pulse mid-line -> all outputs 0 next edge.
